hex_scan_mux: RTL and testbench

Parametrised time-multiplexed hex display scanner for the board's multiplexed seven-segment interface. It drives a digit-select index plus a 4-bit nibble to the on-board hex decoder. It is the general successor to the fixed two-digit scanner: DIGITS-wide, with a configurable dwell time, tear-free double-buffered updates, per-digit enable and blink, and leading-zero suppression. It sits between user logic, which presents a packed nibble word, and the board display pins.

---
 rtl/hex_scan_pkg.sv | 13 +
 rtl/hex_lz_mask.sv | 24 ++
 rtl/hex_scan_mux.sv | 115 +++++++++++
 tb/tb_hex_scan_mux.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
package hex_scan_pkg;

   localparam int         DEF_DWELL        = 250000;
   localparam int         DEF_BLINK_FRAMES = 64;
   localparam logic [3:0] OFF_NIBBLE       = 4'h0;

   // Digit index width, never narrower than one bit.
   function automatic int idx_w(input int digits);
      return (digits < 2) ? 1 : $clog2(digits);
   endfunction

endpackage

// File: rtl/hex_lz_mask.sv
// Leading-zero blank mask: digit i>=1 is blanked when it and every higher digit are zero.
module hex_lz_mask
   import hex_scan_pkg::*;
#(
   parameter int DIGITS = 8
) (
   input  logic [4*DIGITS-1:0] disp_i,
   input  logic                lz_suppress_i,
   output logic [DIGITS-1:0]   blank_o
);

   logic zero_run;

   always_comb begin
      blank_o  = '0;
      zero_run = 1'b1;
      // Walk from the most significant digit down; digit 0 is never blanked.
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run   = zero_run & (disp_i[4*i +: 4] == OFF_NIBBLE);
         blank_o[i] = lz_suppress_i & zero_run;
      end
   end

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexed hex scanner: dwell/idx counters, double-buffered nibble word,
// blink and leading-zero blanking, registered select/data/on outputs.
module hex_scan_mux
   import hex_scan_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int DWELL        = DEF_DWELL,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
   parameter int AW           = idx_w(DIGITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] data_in,
   input  logic                load,
   input  logic [DIGITS-1:0]   digit_en,
   input  logic [DIGITS-1:0]   blink_en,
   input  logic                lz_suppress,
   output logic [AW-1:0]       an,
   output logic [3:0]          hexplay_data,
   output logic                hexplay_on,
   output logic                frame_done
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [AW-1:0] IDX_LAST   = AW'(DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [DW-1:0]       dwell_cnt_q, dwell_cnt_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   logic [AW-1:0]       an_q;
   logic [3:0]          hexplay_data_q, hexplay_data_d;
   logic                hexplay_on_q, hexplay_on_d;

   logic                dwell_wrap;
   logic                frame_end;
   logic [3:0]          sel_nib;
   logic [DIGITS-1:0]   lz_blank;

   hex_lz_mask #(
      .DIGITS (DIGITS)
   ) u_lz_mask (
      .disp_i        (disp_d),
      .lz_suppress_i (lz_suppress),
      .blank_o       (lz_blank)
   );

   always_comb begin
      dwell_wrap    = (dwell_cnt_q == DWELL_LAST);
      frame_end     = dwell_wrap && (idx_q == IDX_LAST);
      dwell_cnt_d   = dwell_wrap ? '0 : dwell_cnt_q + DW'(1);
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;

      if (dwell_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
      end

      // shadow_q here is the pre-load value, so a boundary-cycle load waits a frame.
      shadow_d = load ? data_in : shadow_q;
      disp_d   = frame_end ? shadow_q : disp_q;

      if (frame_end) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end

      // Outputs look at the values the next cycle will hold, so select and data never skew.
      sel_nib        = disp_d[{idx_d, 2'b00} +: 4];
      hexplay_on_d   = digit_en[idx_d] & ~lz_blank[idx_d] &
                       ~(blink_en[idx_d] & blink_phase_d);
      hexplay_data_d = hexplay_on_d ? sel_nib : OFF_NIBBLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_cnt_q    <= '0;
         idx_q          <= '0;
         shadow_q       <= '0;
         disp_q         <= '0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b0;
         an_q           <= '0;
         hexplay_data_q <= OFF_NIBBLE;
         hexplay_on_q   <= 1'b0;
      end else begin
         dwell_cnt_q    <= dwell_cnt_d;
         idx_q          <= idx_d;
         shadow_q       <= shadow_d;
         disp_q         <= disp_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
         an_q           <= idx_d;
         hexplay_data_q <= hexplay_data_d;
         hexplay_on_q   <= hexplay_on_d;
      end
   end

   assign an           = an_q;
   assign hexplay_data = hexplay_data_q;
   assign hexplay_on   = hexplay_on_q;
   assign frame_done   = frame_end;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Directed bench for hex_scan_mux with DIGITS=4, DWELL=3, BLINK_FRAMES=2 (12-cycle frames).
module tb_hex_scan_mux;

   localparam int DIGITS       = 4;
   localparam int DWELL        = 3;
   localparam int BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic        load;
   logic [3:0]  digit_en;
   logic [3:0]  blink_en;
   logic        lz_suppress;
   logic [1:0]  an;
   logic [3:0]  hexplay_data;
   logic        hexplay_on;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   hex_scan_mux #(
      .DIGITS       (DIGITS),
      .DWELL        (DWELL),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .load         (load),
      .digit_en     (digit_en),
      .blink_en     (blink_en),
      .lz_suppress  (lz_suppress),
      .an           (an),
      .hexplay_data (hexplay_data),
      .hexplay_on   (hexplay_on),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      load        = 1'b0;
      data_in     = '0;
      digit_en    = '0;
      blink_en    = '0;
      lz_suppress = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (an !== 2'd0)           begin errors++; $display("FAIL reset_an got %0d want 0", an); end
      if (hexplay_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h want 0", hexplay_data); end
      if (hexplay_on !== 1'b0)   begin errors++; $display("FAIL reset_on got %b want 0", hexplay_on); end
      if (frame_done !== 1'b0)   begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
      rst_n = 1'b1;
      cyc   = 0;
      #1;
      checks += 2;
      if (an !== 2'd0)         begin errors++; $display("FAIL release_an got %0d want 0", an); end
      if (hexplay_on !== 1'b0) begin errors++; $display("FAIL release_on got %b want 0", hexplay_on); end
   endtask

   // Frame 0 shows zeros while 0x1234 waits in the shadow; frame 1 shows it.
   task automatic test_first_frames();
      logic [3:0] tab [2][4];
      logic [1:0] slot;
      int         f;
      tab = '{'{4'h0, 4'h0, 4'h0, 4'h0}, '{4'h4, 4'h3, 4'h2, 4'h1}};
      digit_en = 4'hF;
      data_in  = 16'h1234;
      load     = 1'b1;
      for (int n = 0; n < 23; n++) begin
         tick();
         load = 1'b0;
         slot = 2'((cyc % 12) / 3);
         f    = cyc / 12;
         checks += 4;
         if (an !== slot)              begin errors++; $display("FAIL first_an cyc=%0d got %0d want %0d", cyc, an, slot); end
         if (hexplay_data !== tab[f][slot]) begin errors++; $display("FAIL first_data cyc=%0d got %h want %h", cyc, hexplay_data, tab[f][slot]); end
         if (hexplay_on !== 1'b1)      begin errors++; $display("FAIL first_on cyc=%0d got %b want 1", cyc, hexplay_on); end
         if (frame_done !== (cyc % 12 == 11)) begin errors++; $display("FAIL first_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 12 == 11)); end
      end
   endtask

   // Mid-frame load lands next frame; a boundary-cycle load lands one frame later.
   task automatic test_midframe_load();
      logic [3:0] tab [4][4];
      logic [1:0] slot;
      int         f;
      tab = '{'{4'h4, 4'h3, 4'h2, 4'h1}, '{4'hD, 4'hC, 4'hB, 4'hA},
              '{4'hD, 4'hC, 4'hB, 4'hA}, '{4'h8, 4'h7, 4'h6, 4'h5}};
      for (int n = 0; n < 48; n++) begin
         tick();
         load = 1'b0;
         slot = 2'((cyc % 12) / 3);
         f    = cyc / 12 - 2;
         checks += 4;
         if (an !== slot)              begin errors++; $display("FAIL mid_an cyc=%0d got %0d want %0d", cyc, an, slot); end
         if (hexplay_data !== tab[f][slot]) begin errors++; $display("FAIL mid_data cyc=%0d got %h want %h", cyc, hexplay_data, tab[f][slot]); end
         if (hexplay_on !== 1'b1)      begin errors++; $display("FAIL mid_on cyc=%0d got %b want 1", cyc, hexplay_on); end
         if (frame_done !== (cyc % 12 == 11)) begin errors++; $display("FAIL mid_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 12 == 11)); end
         if (cyc == 27) begin data_in = 16'hABCD; load = 1'b1; end
         if (cyc == 47) begin data_in = 16'h5678; load = 1'b1; end
      end
   endtask

   // Frame 6: 0x5678, frame 7: 0x0050, frame 8: 0x0000, all with lz_suppress=1.
   task automatic test_lz_suppress();
      logic [3:0] tab_d [3][4];
      logic       tab_o [3][4];
      logic [1:0] slot;
      int         f;
      tab_d = '{'{4'h8, 4'h7, 4'h6, 4'h5}, '{4'h0, 4'h5, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}};
      tab_o = '{'{1'b1, 1'b1, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}};
      for (int n = 0; n < 36; n++) begin
         tick();
         load = 1'b0;
         slot = 2'((cyc % 12) / 3);
         f    = cyc / 12 - 6;
         checks += 4;
         if (an !== slot)              begin errors++; $display("FAIL lz_an cyc=%0d got %0d want %0d", cyc, an, slot); end
         if (hexplay_data !== tab_d[f][slot]) begin errors++; $display("FAIL lz_data cyc=%0d got %h want %h", cyc, hexplay_data, tab_d[f][slot]); end
         if (hexplay_on !== tab_o[f][slot])   begin errors++; $display("FAIL lz_on cyc=%0d got %b want %b", cyc, hexplay_on, tab_o[f][slot]); end
         if (frame_done !== (cyc % 12 == 11)) begin errors++; $display("FAIL lz_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 12 == 11)); end
         if (cyc == 72) begin lz_suppress = 1'b1; data_in = 16'h0050; load = 1'b1; end
         if (cyc == 84) begin data_in = 16'h0000; load = 1'b1; end
         if (cyc == 96) begin data_in = 16'h1234; load = 1'b1; end
      end
   endtask

   // Blink phase per frame f is (f/2)%2; digit 0 lit in frames 9 and 12, dark in 10 and 11.
   task automatic test_blink();
      logic       lit0 [4];
      logic [3:0] want_d;
      logic       want_o;
      logic [3:0] nib [4];
      logic [1:0] slot;
      int         f;
      lit0 = '{1'b1, 1'b0, 1'b0, 1'b1};
      nib  = '{4'h4, 4'h3, 4'h2, 4'h1};
      lz_suppress = 1'b0;
      blink_en    = 4'b0001;
      for (int n = 0; n < 48; n++) begin
         tick();
         slot   = 2'((cyc % 12) / 3);
         f      = cyc / 12 - 9;
         want_o = (slot == 2'd0) ? lit0[f] : 1'b1;
         want_d = want_o ? nib[slot] : 4'h0;
         checks += 4;
         if (an !== slot)           begin errors++; $display("FAIL blink_an cyc=%0d got %0d want %0d", cyc, an, slot); end
         if (hexplay_data !== want_d) begin errors++; $display("FAIL blink_data cyc=%0d got %h want %h", cyc, hexplay_data, want_d); end
         if (hexplay_on !== want_o) begin errors++; $display("FAIL blink_on cyc=%0d got %b want %b", cyc, hexplay_on, want_o); end
         if (frame_done !== (cyc % 12 == 11)) begin errors++; $display("FAIL blink_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 12 == 11)); end
      end
   endtask

   task automatic test_digit_en();
      logic [3:0] want_d [4];
      logic       want_o [4];
      logic [1:0] slot;
      want_d = '{4'h0, 4'h3, 4'h0, 4'h1};
      want_o = '{1'b0, 1'b1, 1'b0, 1'b1};
      blink_en = 4'b0000;
      digit_en = 4'b1010;
      for (int n = 0; n < 12; n++) begin
         tick();
         slot = 2'((cyc % 12) / 3);
         checks += 4;
         if (an !== slot)                 begin errors++; $display("FAIL en_an cyc=%0d got %0d want %0d", cyc, an, slot); end
         if (hexplay_data !== want_d[slot]) begin errors++; $display("FAIL en_data cyc=%0d got %h want %h", cyc, hexplay_data, want_d[slot]); end
         if (hexplay_on !== want_o[slot]) begin errors++; $display("FAIL en_on cyc=%0d got %b want %b", cyc, hexplay_on, want_o[slot]); end
         if (frame_done !== (cyc % 12 == 11)) begin errors++; $display("FAIL en_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 12 == 11)); end
      end
   endtask

   // Pending shadow 0xEEEE must be discarded by a mid-frame reset.
   task automatic test_reset_mid();
      logic [1:0] slot;
      digit_en = 4'hF;
      while (cyc < 174) begin
         tick();
         load = 1'b0;
         if (cyc == 169) begin data_in = 16'hEEEE; load = 1'b1; end
      end
      checks += 2;
      if (an !== 2'd2)           begin errors++; $display("FAIL pre_rst_an got %0d want 2", an); end
      if (hexplay_data !== 4'h2) begin errors++; $display("FAIL pre_rst_data got %h want 2", hexplay_data); end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (an !== 2'd0)           begin errors++; $display("FAIL async_rst_an got %0d want 0", an); end
      if (hexplay_on !== 1'b0)   begin errors++; $display("FAIL async_rst_on got %b want 0", hexplay_on); end
      if (hexplay_data !== 4'h0) begin errors++; $display("FAIL async_rst_data got %h want 0", hexplay_data); end
      if (frame_done !== 1'b0)   begin errors++; $display("FAIL async_rst_fd got %b want 0", frame_done); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      for (int n = 0; n < 24; n++) begin
         tick();
         slot = 2'((cyc % 12) / 3);
         checks += 4;
         if (an !== slot)           begin errors++; $display("FAIL post_rst_an cyc=%0d got %0d want %0d", cyc, an, slot); end
         if (hexplay_data !== 4'h0) begin errors++; $display("FAIL post_rst_data cyc=%0d got %h want 0", cyc, hexplay_data); end
         if (hexplay_on !== 1'b1)   begin errors++; $display("FAIL post_rst_on cyc=%0d got %b want 1", cyc, hexplay_on); end
         if (frame_done !== (cyc % 12 == 11)) begin errors++; $display("FAIL post_rst_fd cyc=%0d got %b want %b", cyc, frame_done, (cyc % 12 == 11)); end
      end
   endtask

   initial begin
      test_reset();
      test_first_frames();
      test_midframe_load();
      test_lz_suppress();
      test_blink();
      test_digit_en();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
